// File: rtl/gamepad_pmod_transmitter.sv
// gamepad_pmod_transmitter
//
// Transmitting end of the three-wire Gamepad Pmod link. Each frame starts
// by taking a snapshot of the button word. The word is shifted out MSB-first
// on pmod_data, one bit per pmod_clk period. A latch pulse and an idle gap
// follow. Frames repeat while enable is high.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   enable      start a new frame when seen high in IDLE
//   present     0 sends an all-ones frame ("no controller")
//   buttons     button word, 1 = pressed, MSB sent first
//   pmod_data   serial data, stable for HALF_PERIOD cycles around each clk rise
//   pmod_clk    serial clock, high exactly in CLK_HI cycles
//   pmod_latch  latch, high exactly in LATCH cycles
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse on the first GAP cycle
//
// Every output is a flop. The registered outputs are computed from the
// next state, so each one tracks the state register with no added cycle.
module gamepad_pmod_transmitter #(
  parameter int BIT_WIDTH   = 12,
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 present,
  input  logic [BIT_WIDTH-1:0] buttons,
  output logic                 pmod_data,
  output logic                 pmod_clk,
  output logic                 pmod_latch,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] CLK_LO = 3'd2;
  localparam logic [2:0] CLK_HI = 3'd3;
  localparam logic [2:0] LATCH  = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  localparam int PHASE_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int BCW       = $clog2(BIT_WIDTH + 1);

  localparam logic [PW-1:0]  HALF_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0]  GAP_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [BCW-1:0] BITS_INIT = BCW'(BIT_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(1);

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [PW-1:0]        phase;
  logic [BCW-1:0]       bit_cnt;
  logic [BIT_WIDTH-1:0] shift_reg;
  logic                 half_done;
  logic                 gap_done;

  assign half_done = (phase == HALF_LAST);
  assign gap_done  = (phase == GAP_LAST);

  // The MSB of the shift register is itself a flop, so data needs no extra stage.
  assign pmod_data = shift_reg[BIT_WIDTH-1];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)    state_next = LOAD;
      LOAD:                   state_next = CLK_LO;
      CLK_LO:  if (half_done) state_next = CLK_HI;
      CLK_HI:  if (half_done) state_next = (bit_cnt == LAST_BIT) ? LATCH : CLK_LO;
      LATCH:   if (half_done) state_next = GAP;
      GAP:     if (gap_done)  state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      pmod_clk   <= 1'b0;
      pmod_latch <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_next;

      // The phase counter restarts on every state change. It stays at 0 in IDLE.
      if (state_next != state) begin
        phase <= '0;
      end else if (state != IDLE) begin
        phase <= phase + 1'b1;
      end

      pmod_clk   <= (state_next == CLK_HI);
      pmod_latch <= (state_next == LATCH);
      busy       <= (state_next != IDLE);
      frame_done <= (state == LATCH) && (state_next == GAP);

      if (state == LOAD) begin
        shift_reg <= present ? buttons : '1;
        bit_cnt   <= BITS_INIT;
      end else if ((state == CLK_HI) && half_done) begin
        // Shifting at the end of CLK_HI gives a full half period of hold
        // after the rise. Zero fill leaves pmod_data low during LATCH.
        shift_reg <= {shift_reg[BIT_WIDTH-2:0], 1'b0};
        bit_cnt   <= bit_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_transmitter.sv
// Directed testbench for gamepad_pmod_transmitter.
// One instance uses the default parameters (12 bits, H=4, gap 16).
// A second instance uses 24 bits with H=2.
// The bench contains a receiver model for each instance. Each model shifts
// in pmod_data on every pmod_clk rise. On each latch rise it checks the
// received word against a queue of expected words.
module tb_gamepad_pmod_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        present;
  logic [11:0] buttons;
  logic        pmod_data, pmod_clk, pmod_latch, busy, frame_done;

  logic        en2;
  logic [23:0] buttons2;
  logic        d2_data, d2_clk, d2_latch, d2_busy, d2_done;

  always #5 clk = ~clk;

  gamepad_pmod_transmitter dut (
    .clk(clk), .reset(reset), .enable(enable), .present(present),
    .buttons(buttons), .pmod_data(pmod_data), .pmod_clk(pmod_clk),
    .pmod_latch(pmod_latch), .busy(busy), .frame_done(frame_done)
  );

  gamepad_pmod_transmitter #(.BIT_WIDTH(24), .HALF_PERIOD(2), .GAP_CYCLES(16)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .present(1'b1),
    .buttons(buttons2), .pmod_data(d2_data), .pmod_clk(d2_clk),
    .pmod_latch(d2_latch), .busy(d2_busy), .frame_done(d2_done)
  );

  // scoreboard
  logic [11:0] exp_q[$];
  logic [23:0] exp2_q[$];
  int tests = 0;
  int fails = 0;

  // receiver model state, single controller
  int          cyc = 0;
  logic [11:0] rx = '0;
  int          rises = 0;
  int          latch_total = 0;
  int          latch_len = 0;
  int          last_latch = -1;
  int          done_total = 0;
  bit          period_on = 1'b0;
  logic        prev_clk = 1'b0, prev_latch = 1'b0, prev_data = 1'b0;

  // receiver model state, dual controller
  logic [23:0] rx2 = '0;
  int          rises2 = 0;
  int          latch2_total = 0;
  int          last2 = -1;
  logic        prev2_clk = 1'b0, prev2_latch = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. Outputs are sampled on the falling edge, and both
  // receiver models are updated there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pmod_clk && !prev_clk) begin
      check("data_setup", 32'(pmod_data), 32'(prev_data));
      rx = {rx[10:0], pmod_data};
      rises++;
    end
    if (pmod_latch && !prev_latch) begin
      latch_total++;
      check("latch_data_clk_low", 32'({pmod_data, pmod_clk}), 32'd0);
      check("latch_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_word", 32'(rx), 32'(exp_q.pop_front()));
      check("clk_rises", 32'(rises), 32'd12);
      if (period_on && last_latch >= 0) check("frame_period", 32'(cyc - last_latch), 32'd118);
      rises = 0;
      last_latch = cyc;
      latch_len = 0;
    end
    if (pmod_latch) latch_len++;
    if (!pmod_latch && prev_latch) check("latch_len", 32'(latch_len), 32'd4);
    if (frame_done) begin
      done_total++;
      check("done_pos", 32'(cyc - last_latch), 32'd4);
    end
    if (d2_clk && !prev2_clk) begin
      rx2 = {rx2[22:0], d2_data};
      rises2++;
    end
    if (d2_latch && !prev2_latch) begin
      latch2_total++;
      check("dual_expected", 32'(exp2_q.size() != 0), 32'd1);
      if (exp2_q.size() != 0) check("dual_word", 32'(rx2), 32'(exp2_q.pop_front()));
      check("dual_rises", 32'(rises2), 32'd24);
      if (last2 >= 0) check("dual_period", 32'(cyc - last2), 32'd116);
      rises2 = 0;
      last2 = cyc;
    end
    prev_clk = pmod_clk;
    prev_latch = pmod_latch;
    prev_data = pmod_data;
    prev2_clk = d2_clk;
    prev2_latch = d2_latch;
  endtask

  task automatic wait_latches(input int n, input int budget);
    int s;
    s = latch_total;
    for (int i = 0; i < budget && latch_total < s + n; i++) tick();
    check("latch_timeout", 32'(latch_total - s), 32'(n));
  endtask

  task automatic wait_rises(input int n, input int budget);
    for (int i = 0; i < budget && rises < n; i++) tick();
    check("rise_timeout", 32'(rises), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    int l0;
    reset = 1'b1; enable = 1'b0; present = 1'b1; buttons = '0;
    en2 = 1'b0; buttons2 = {12'hFFF, 12'h040};

    // reset state
    for (int i = 0; i < 3; i++) tick();
    check("reset_outputs", 32'({pmod_data, pmod_clk, pmod_latch, busy, frame_done}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_outputs", 32'({pmod_data, pmod_clk, pmod_latch, busy, frame_done}), 32'd0);

    // loopback: two back-to-back frames of 12'h801
    buttons = 12'h801; present = 1'b1; period_on = 1'b1; last_latch = -1;
    exp_q.push_back(12'h801); exp_q.push_back(12'h801);
    enable = 1'b1;
    wait_latches(2, 400);
    enable = 1'b0;
    wait_idle(100);
    check("done_count_loopback", 32'(done_total), 32'd2);

    // absent controller: frame of all ones
    present = 1'b0; buttons = 12'h000; period_on = 1'b0; last_latch = -1;
    exp_q.push_back(12'hFFF);
    enable = 1'b1;
    wait_latches(1, 200);
    enable = 1'b0;
    wait_idle(100);

    // snapshot stability: change buttons after the 3rd clock rise
    present = 1'b1; buttons = 12'hA5A; period_on = 1'b1; last_latch = -1;
    exp_q.push_back(12'hA5A); exp_q.push_back(12'h5A5);
    enable = 1'b1;
    wait_rises(3, 100);
    buttons = 12'h5A5;
    wait_latches(2, 400);
    enable = 1'b0;
    wait_idle(100);

    // enable dropped mid-frame: the frame completes, then stays idle
    buttons = 12'h3C3; period_on = 1'b0; last_latch = -1;
    exp_q.push_back(12'h3C3);
    d0 = done_total;
    enable = 1'b1;
    wait_rises(5, 100);
    enable = 1'b0;
    wait_idle(200);
    check("done_once_after_drop", 32'(done_total - d0), 32'd1);
    for (int i = 0; i < 300; i++) tick();
    check("no_rises_when_idle", 32'(rises), 32'd0);
    check("busy_stays_low", 32'(busy), 32'd0);
    check("no_done_when_idle", 32'(done_total - d0), 32'd1);

    // reset asserted in CLK_HI: outputs clear at once, and no latch follows
    buttons = 12'h123; l0 = latch_total;
    enable = 1'b1;
    wait_rises(2, 100);
    for (int i = 0; i < 20 && !pmod_clk; i++) tick();
    check("clk_high_seen", 32'(pmod_clk), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'({pmod_data, pmod_clk, pmod_latch, busy, frame_done}), 32'd0);
    enable = 1'b0;
    tick(); tick();
    reset = 1'b0;
    rises = 0;
    for (int i = 0; i < 150; i++) tick();
    check("no_latch_after_reset", 32'(latch_total - l0), 32'd0);
    check("busy_after_reset", 32'(busy), 32'd0);

    // dual controllers: two back-to-back 24-bit frames
    exp2_q.push_back({12'hFFF, 12'h040}); exp2_q.push_back({12'hFFF, 12'h040});
    en2 = 1'b1;
    for (int i = 0; i < 400 && latch2_total < 2; i++) tick();
    check("dual_latch_timeout", 32'(latch2_total), 32'd2);
    en2 = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check("dual_idle", 32'(d2_busy), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("dual_queue_drained", 32'(exp2_q.size()), 32'd0);
    check("done_matches_latches", 32'(done_total), 32'(latch_total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
